mem_fill_responder: RTL and testbench
=====================================

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 Parameter: LATENCY, default 4, request-to-data delay in cycles; legal range 1..8.
REQ-002 Parameter: IDX_W, default 8, word-index width; storage is 2^IDX_W words.
REQ-003 Parameter: DATA_W, default 16, data word width.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: memory_read  input  1  read request strobe, one request per asserted cycle.
REQ-007 Port: memory_address  input  16  byte address of read request.
REQ-008 Port: memory_write  input  1  write strobe.
REQ-009 Port: write_address  input  16  byte address of write.
REQ-010 Port: write_data  input  DATA_W  write data.
REQ-011 Port: memory_data  output  DATA_W  returned read data.
REQ-012 Port: memory_data_valid  output  1  memory_data/data_address valid this cycle.
REQ-013 Port: data_address  output  16  byte address of request being returned.
REQ-014 Port: outstanding  output  4  count of accepted reads not yet returned.

Function
REQ-015 Storage SHALL be word-indexed by address[IDX_W:1]; bit 0 ignored; higher bits ignored (aliasing modulo 2^IDX_W words).
REQ-016 Reads SHALL be fully pipelined: no stall, no backpressure, one request accepted every cycle memory_read=1.
REQ-017 Request accepted at edge N SHALL produce memory_data_valid=1 in cycle after edge N+LATENCY-1 (i.e. registered, LATENCY edges after acceptance), exactly one cycle wide.
REQ-018 Returns SHALL be in request order; back-to-back requests yield back-to-back valid cycles.
REQ-019 memory_data SHALL equal storage contents at the acceptance edge; same-cycle write to same word returns OLD data (read-before-write).
REQ-020 Write SHALL update storage at the edge it is sampled; reads accepted at later edges see new data.
REQ-021 memory_read and memory_write in same cycle, any addresses, SHALL both be performed.
REQ-022 data_address SHALL echo full 16-bit memory_address of returned request, including bit 0 and aliased bits.
REQ-023 When memory_data_valid=0, memory_data and data_address SHALL be 0.
REQ-024 outstanding SHALL increment on accept, decrement on return, unchanged when both occur same cycle; max value LATENCY, never wraps.
REQ-025 Pipeline structure: LATENCY-stage shift register of {valid, address, data}; no FSM beyond stage valid bits.

Reset
REQ-026 rst=1 at an edge SHALL clear all stage valid bits; memory_data_valid=0, memory_data=0, data_address=0, outstanding=0 next cycle.
REQ-027 Requests in flight at reset SHALL be discarded; no valid pulse for them after rst deasserts.
REQ-028 memory_read/memory_write sampled while rst=1 SHALL be ignored; storage contents SHALL NOT be altered by reset.
REQ-029 First request accepted at edge after rst deasserts SHALL return with normal LATENCY.

Verification
REQ-030 Preload word 0x1234>>1 (index 0x1A) with 0xBEEF; single read 0x1234 -> valid exactly 4 cycles later, memory_data=0xBEEF, data_address=0x1234, outstanding 1 then 0.
REQ-031 Preload 0x1230..0x123E with 0xA000..0xA007; 8 back-to-back reads -> 8 consecutive valid cycles starting 4 cycles after first, data 0xA000..0xA007 in order, outstanding peaks at 4.
REQ-032 Word holds 0x1111; same cycle read+write 0x2222 to it -> returns 0x1111; read next cycle -> returns 0x2222.
REQ-033 Issue 3 reads, assert rst 2 cycles later for 1 cycle -> no valid pulses ever, outputs 0, outstanding 0; storage preserved on subsequent read.
REQ-034 Read 0x0201 with IDX_W=8 -> returns word at index 0x00, data_address=0x0201 (alias and bit-0 ignored).
REQ-035 LATENCY=1 build: read each cycle for 5 cycles -> valid each following cycle, outstanding never exceeds 1.

Source files
------------

// File: rtl/mem_fill_responder_if.sv
// Read/write bus between a requester (master) and mem_fill_responder (slave).
// clk and rst stay plain ports on the modules.
interface mem_fill_responder_if #(
  parameter int DATA_W = 16
);
  logic              memory_read;
  logic [15:0]       memory_address;
  logic              memory_write;
  logic [15:0]       write_address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic [15:0]       data_address;
  logic [3:0]        outstanding;

  modport master (
    output memory_read, memory_address, memory_write, write_address, write_data,
    input  memory_data, memory_data_valid, data_address, outstanding
  );

  modport slave (
    input  memory_read, memory_address, memory_write, write_address, write_data,
    output memory_data, memory_data_valid, data_address, outstanding
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Fixed-latency, fully pipelined word memory responder: every read is answered
// LATENCY edges after acceptance, in order, through a {valid, address, data} shift register.
module mem_fill_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8,
  parameter int DATA_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  mem_fill_responder_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [LATENCY-1:0] r_stValid;
  logic [15:0]        r_stAddr [LATENCY];
  logic [DATA_W-1:0]  r_stData [LATENCY];
  logic [3:0]         r_outstanding;

  logic [IDX_W-1:0]   w_readIdx;
  logic [IDX_W-1:0]   w_writeIdx;
  logic               w_retire;
  logic [31:0]        w_unusedAddr;

  // Byte addresses select words; bit 0 and bits above IDX_W alias.
  assign w_readIdx    = bus.memory_address[IDX_W:1];
  assign w_writeIdx   = bus.write_address[IDX_W:1];
  assign w_unusedAddr = {bus.memory_address, bus.write_address};
  assign w_retire     = r_stValid[LATENCY-1];

  // Storage is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.memory_write) begin
      r_mem[w_writeIdx] <= bus.write_data;
    end
  end

  // Stage 0 captures pre-write contents, giving read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stValid     <= '0;
      r_outstanding <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_stAddr[i] <= '0;
        r_stData[i] <= '0;
      end
    end else begin
      r_stValid[0] <= bus.memory_read;
      r_stAddr[0]  <= bus.memory_read ? bus.memory_address : 16'h0000;
      r_stData[0]  <= bus.memory_read ? r_mem[w_readIdx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_stValid[i] <= r_stValid[i-1];
        r_stAddr[i]  <= r_stAddr[i-1];
        r_stData[i]  <= r_stData[i-1];
      end
      case ({bus.memory_read, w_retire})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Empty stages carry zeros, so the last stage drives the outputs directly.
  assign bus.memory_data_valid = r_stValid[LATENCY-1];
  assign bus.memory_data       = r_stData[LATENCY-1];
  assign bus.data_address      = r_stAddr[LATENCY-1];
  assign bus.outstanding       = r_outstanding;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Randomized and directed bench for mem_fill_responder against a queue-based
// behavioural model of in-order fixed-latency responses.
module tb_mem_fill_responder;
  localparam int LAT = 4;
  localparam int DW  = 16;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst1;

  always #5 clk = ~clk;

  mem_fill_responder_if #(.DATA_W(DW)) bus ();
  mem_fill_responder_if #(.DATA_W(DW)) bus1 ();

  mem_fill_responder #(.LATENCY(LAT), .IDX_W(8), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_fill_responder #(.LATENCY(1), .IDX_W(8), .DATA_W(DW)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );

  resp_t       pending [$];
  logic [15:0] modelMem [256];
  int          edgeCnt = 0;
  int          total   = 0;
  int          bad     = 0;
  logic        expValid;
  logic [15:0] expData;
  logic [15:0] expAddr;
  logic [3:0]  expOut;

  // One clock of stimulus on the main DUT; the model predicts what the outputs show after this edge.
  task automatic cycle(input logic rd, input logic [15:0] ra, input logic wr,
                       input logic [15:0] wa, input logic [15:0] wd, input logic rs);
    resp_t r;
    bus.memory_read    = rd;
    bus.memory_address = ra;
    bus.memory_write   = wr;
    bus.write_address  = wa;
    bus.write_data     = wd;
    rst                = rs;
    @(posedge clk);
    edgeCnt++;
    if (rs) begin
      pending.delete();
    end else begin
      if (rd) begin
        r.due  = edgeCnt + LAT - 1;
        r.addr = ra;
        r.data = modelMem[ra[8:1]];
        pending.push_back(r);
      end
      if (wr) modelMem[wa[8:1]] = wd;
    end
    while (pending.size() > 0 && pending[0].due < edgeCnt) void'(pending.pop_front());
    expValid = (pending.size() > 0) && (pending[0].due == edgeCnt);
    expData  = expValid ? pending[0].data : 16'h0000;
    expAddr  = expValid ? pending[0].addr : 16'h0000;
    expOut   = 4'(pending.size());
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b1);
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {1'b0, 16'h0000, 16'h0000, 4'd0}) begin
        bad++;
        $display("[TB] FAIL reset: got v=%b d=%h a=%h o=%0d want all zero",
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding);
      end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) cycle(1'b0, 16'h0, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);
  endtask

  task automatic test_single();
    int seenAt = -1;
    logic [15:0] seenData = 16'h0, seenAddr = 16'h0;
    cycle(1'b0, 16'h0, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cycle(k == 0, 16'h1234, 1'b0, 16'h0, 16'h0, 1'b0);
      if (bus.memory_data_valid === 1'b1) begin
        seenAt = k; seenData = bus.memory_data; seenAddr = bus.data_address;
      end
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {expValid, expData, expAddr, expOut}) begin
        bad++;
        $display("[TB] FAIL single k=%0d: got v=%b d=%h a=%h o=%0d want v=%b d=%h a=%h o=%0d", k,
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding,
                 expValid, expData, expAddr, expOut);
      end
    end
    total++;
    if ({seenAt, seenData, seenAddr} !== {32'sd3, 16'hBEEF, 16'h1234}) begin
      bad++;
      $display("[TB] FAIL single_timing: got at=%0d d=%h a=%h want at=3 d=beef a=1234",
               seenAt, seenData, seenAddr);
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0, nValid = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1, 16'(16'h1230 + i * 2), 16'(16'hA000 + i), 1'b0);
    for (int k = 0; k < 14; k++) begin
      cycle(k < 8, 16'(16'h1230 + k * 2), 1'b0, 16'h0, 16'h0, 1'b0);
      if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
      if (bus.memory_data_valid === 1'b1) begin
        total++;
        if ({k, bus.memory_data} !== {nValid + 3, 16'(16'hA000 + nValid)}) begin
          bad++;
          $display("[TB] FAIL b2b_order: got k=%0d d=%h want k=%0d d=%h", k, bus.memory_data,
                   nValid + 3, 16'(16'hA000 + nValid));
        end
        nValid++;
      end
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {expValid, expData, expAddr, expOut}) begin
        bad++;
        $display("[TB] FAIL b2b k=%0d: got v=%b d=%h a=%h o=%0d want v=%b d=%h a=%h o=%0d", k,
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding,
                 expValid, expData, expAddr, expOut);
      end
    end
    total++;
    if ({peak, nValid} !== {32'sd4, 32'sd8}) begin
      bad++;
      $display("[TB] FAIL b2b_peak: got peak=%0d n=%0d want peak=4 n=8", peak, nValid);
    end
  endtask

  task automatic test_rbw();
    logic [15:0] got [$];
    cycle(1'b0, 16'h0, 1'b1, 16'h0050, 16'h1111, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cycle(k < 2, 16'h0050, k == 0, 16'h0050, 16'h2222, 1'b0);
      if (bus.memory_data_valid === 1'b1) got.push_back(bus.memory_data);
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {expValid, expData, expAddr, expOut}) begin
        bad++;
        $display("[TB] FAIL rbw k=%0d: got v=%b d=%h a=%h o=%0d want v=%b d=%h a=%h o=%0d", k,
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding,
                 expValid, expData, expAddr, expOut);
      end
    end
    total++;
    if (got.size() != 2 || got[0] !== 16'h1111 || got[1] !== 16'h2222) begin
      bad++;
      $display("[TB] FAIL rbw_values: got n=%0d want n=2 data 1111 then 2222", got.size());
    end
  endtask

  task automatic test_reset_flush();
    int nValid = 0;
    logic [15:0] after = 16'h0;
    for (int k = 0; k < 14; k++) begin
      cycle(k < 4 || k == 8, (k == 8) ? 16'h1234 : 16'(16'h1232 + k * 2), k == 3, 16'h1234,
            16'hDEAD, k == 3);
      if (bus.memory_data_valid === 1'b1) begin
        if (k < 8) nValid++;
        else after = bus.memory_data;
      end
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {expValid, expData, expAddr, expOut}) begin
        bad++;
        $display("[TB] FAIL flush k=%0d: got v=%b d=%h a=%h o=%0d want v=%b d=%h a=%h o=%0d", k,
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding,
                 expValid, expData, expAddr, expOut);
      end
    end
    total++;
    if ({nValid, after} !== {32'sd0, 16'hA002}) begin
      bad++;
      $display("[TB] FAIL flush_result: got pulses=%0d data=%h want pulses=0 data=a002", nValid, after);
    end
  endtask

  task automatic test_alias();
    logic [15:0] gotD = 16'h0, gotA = 16'h0;
    cycle(1'b0, 16'h0, 1'b1, 16'h7E00, 16'h5A5A, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, 16'h0201, 1'b0, 16'h0, 16'h0, 1'b0);
      if (bus.memory_data_valid === 1'b1) begin
        gotD = bus.memory_data; gotA = bus.data_address;
      end
    end
    total++;
    if ({gotD, gotA} !== {16'h5A5A, 16'h0201}) begin
      bad++;
      $display("[TB] FAIL alias: got d=%h a=%h want d=5a5a a=0201", gotD, gotA);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 39) == 0);
      total++;
      if ({bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding} !==
          {expValid, expData, expAddr, expOut}) begin
        bad++;
        $display("[TB] FAIL random k=%0d: got v=%b d=%h a=%h o=%0d want v=%b d=%h a=%h o=%0d", k,
                 bus.memory_data_valid, bus.memory_data, bus.data_address, bus.outstanding,
                 expValid, expData, expAddr, expOut);
      end
    end
  endtask

  task automatic test_latency1();
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    total++;
    if ({bus1.memory_data_valid, bus1.outstanding} !== {1'b0, 4'd0}) begin
      bad++;
      $display("[TB] FAIL lat1_reset: got v=%b o=%0d want v=0 o=0",
               bus1.memory_data_valid, bus1.outstanding);
    end
    for (int i = 0; i < 5; i++) begin
      bus1.memory_write  = 1'b1;
      bus1.write_address = 16'(i * 2);
      bus1.write_data    = 16'(16'hC000 + i);
      @(posedge clk); #1;
    end
    bus1.memory_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus1.memory_read    = (i < 5);
      bus1.memory_address = 16'(i * 2);
      @(posedge clk); #1;
      total++;
      if (i < 5) begin
        if ({bus1.memory_data_valid, bus1.memory_data, bus1.data_address, bus1.outstanding} !==
            {1'b1, 16'(16'hC000 + i), 16'(i * 2), 4'd1}) begin
          bad++;
          $display("[TB] FAIL lat1 i=%0d: got v=%b d=%h a=%h o=%0d want v=1 d=%h a=%h o=1", i,
                   bus1.memory_data_valid, bus1.memory_data, bus1.data_address, bus1.outstanding,
                   16'(16'hC000 + i), 16'(i * 2));
        end
      end else if ({bus1.memory_data_valid, bus1.memory_data, bus1.data_address, bus1.outstanding} !==
                   {1'b0, 16'h0000, 16'h0000, 4'd0}) begin
        bad++;
        $display("[TB] FAIL lat1_idle: got v=%b d=%h a=%h o=%0d want all zero",
                 bus1.memory_data_valid, bus1.memory_data, bus1.data_address, bus1.outstanding);
      end
    end
    bus1.memory_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rst1 = 1'b1;
    bus.memory_read = 1'b0;   bus.memory_address = '0;  bus.memory_write = 1'b0;
    bus.write_address = '0;   bus.write_data = '0;
    bus1.memory_read = 1'b0;  bus1.memory_address = '0; bus1.memory_write = 1'b0;
    bus1.write_address = '0;  bus1.write_data = '0;
    test_reset();
    preload();
    test_single();
    test_back_to_back();
    test_rbw();
    test_reset_flush();
    test_alias();
    test_random();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
